// File: rtl/pause_quanta_timer_tx.sv
// Turns 802.3x pause quanta into a TX hold window applied only at frame boundaries.
// Latency: accept -> tx_pause on the next edge; always ready, never backpressures.
module pause_quanta_timer_tx #(
    parameter int CYCLES_PER_QUANTA = 8,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [15:0]          in_data,
    output logic                 in_ready,
    input  logic                 tx_frame_active,
    input  logic                 cfg_pause_ignore,
    output logic                 tx_pause,
    output logic                 tx_pause_pending,
    output logic [15:0]          pause_remaining,
    output logic [CNT_WIDTH-1:0] pause_frame_count
);

    localparam int SUB_W = (CYCLES_PER_QUANTA > 1) ? $clog2(CYCLES_PER_QUANTA) : 1;
    localparam logic [SUB_W-1:0] SUB_RELOAD = SUB_W'(CYCLES_PER_QUANTA - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EOF,
        PAUSED
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      quanta_q, quanta_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             accept;
    logic             q_zero;

    assign accept = in_valid && in_ready;
    assign q_zero = (in_data == 16'd0);

    // quanta_cnt is kept at zero whenever the next state is IDLE so it can
    // feed pause_remaining directly.
    always_comb begin
        state_d  = state_q;
        quanta_d = quanta_q;
        sub_d    = sub_q;
        if (cfg_pause_ignore) begin
            state_d  = IDLE;
            quanta_d = 16'd0;
            sub_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && !q_zero) begin
                        quanta_d = in_data;
                        sub_d    = SUB_RELOAD;
                        state_d  = tx_frame_active ? WAIT_EOF : PAUSED;
                    end
                end
                WAIT_EOF: begin
                    if (accept) begin
                        quanta_d = in_data;
                    end
                    if (accept && q_zero) begin
                        state_d  = IDLE;
                        quanta_d = 16'd0;
                        sub_d    = '0;
                    end else if (!tx_frame_active) begin
                        state_d = PAUSED;
                        sub_d   = SUB_RELOAD;
                    end
                end
                PAUSED: begin
                    // A fresh pause word always wins over expiry in the same cycle.
                    if (accept) begin
                        if (q_zero) begin
                            state_d  = IDLE;
                            quanta_d = 16'd0;
                            sub_d    = '0;
                        end else begin
                            quanta_d = in_data;
                            sub_d    = SUB_RELOAD;
                        end
                    end else if (sub_q == '0) begin
                        if (quanta_q == 16'd1) begin
                            state_d  = IDLE;
                            quanta_d = 16'd0;
                            sub_d    = '0;
                        end else begin
                            quanta_d = quanta_q - 16'd1;
                            sub_d    = SUB_RELOAD;
                        end
                    end else begin
                        sub_d = sub_q - 1'b1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    quanta_d = 16'd0;
                    sub_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            quanta_q <= 16'd0;
            sub_q    <= '0;
        end else begin
            state_q  <= state_d;
            quanta_q <= quanta_d;
            sub_q    <= sub_d;
        end
    end

    // Outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready         <= 1'b0;
            tx_pause         <= 1'b0;
            tx_pause_pending <= 1'b0;
            pause_remaining  <= 16'd0;
        end else begin
            in_ready         <= 1'b1;
            tx_pause         <= (state_d == PAUSED);
            tx_pause_pending <= (state_d == WAIT_EOF);
            pause_remaining  <= quanta_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_frame_count <= '0;
        end else if (accept && (pause_frame_count != {CNT_WIDTH{1'b1}})) begin
            pause_frame_count <= pause_frame_count + 1'b1;
        end
    end

endmodule
